// File: rtl/rfphoenix_mem_req_dispatch.sv
// Memory request dispatcher: pops one queued request at a time and runs it as
// a single bus cycle, then holds the completed request until the consumer takes it.
`timescale 1ns/1ps

package rfphoenix_mem_pkg;
    typedef enum logic [3:0] {
        MR_NOP   = 4'd0,
        MR_LOAD  = 4'd1,
        MR_LOADZ = 4'd2,
        MR_STORE = 4'd3,
        MR_CACHE = 4'd4
    } mem_func_e;

    typedef enum logic [2:0] {
        SZ_BYT   = 3'd0,
        SZ_WYDE  = 3'd1,
        SZ_TETRA = 3'd2,
        SZ_OCTA  = 3'd3
    } mem_size_e;

    typedef struct packed {
        mem_func_e      func;
        mem_size_e      sz;
        logic [31:0]    adr;
        logic [127:0]   dat;
        logic [7:0]     tid;
    } sMemoryRequest;
endpackage

module rfphoenix_mem_req_dispatch
    import rfphoenix_mem_pkg::*;
#(
    parameter int AWID  = 32,
    parameter int TOCNT = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  sMemoryRequest   req,
    output logic            rd,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [15:0]     sel_o,
    output logic [AWID-1:0] adr_o,
    output logic [127:0]    dat_o,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic [127:0]    dat_i,
    output logic            resp_valid,
    output sMemoryRequest   resp,
    output logic            resp_err,
    input  logic            resp_rdy
);

    localparam int CW = (TOCNT > 1) ? $clog2(TOCNT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e         state;
    sMemoryRequest  cap;
    logic [CW-1:0]  tmo;

    logic [15:0]    size_mask;
    logic [31:0]    lane_wide;
    logic           lane_ovf;
    logic           is_read;
    logic           is_write;
    logic [AWID-1:0] adr_full;
    logic [127:0]   store_dat;
    logic [127:0]   load_raw;
    sMemoryRequest  done_resp;
    sMemoryRequest  reject_resp;

    // Align the loaded lanes to bit 0, then trim/extend to the access size.
    function automatic logic [127:0] load_extend(input mem_func_e f, input mem_size_e s,
                                                 input logic [127:0] raw);
        logic sx;
        sx = (f == MR_LOAD);
        case (s)
            SZ_BYT:   return {96'h0, {24{sx & raw[7]}}, raw[7:0]};
            SZ_WYDE:  return {96'h0, {16{sx & raw[15]}}, raw[15:0]};
            SZ_TETRA: return {96'h0, raw[31:0]};
            default:  return {64'h0, raw[63:0]};
        endcase
    endfunction

    always_comb begin
        case (req.sz)
            SZ_BYT:   size_mask = 16'h0001;
            SZ_WYDE:  size_mask = 16'h0003;
            SZ_TETRA: size_mask = 16'h000F;
            default:  size_mask = 16'h00FF;
        endcase
    end

    // Lanes pushed past lane 15 mean the access straddles the 16-byte bus word.
    assign lane_wide = {16'h0, size_mask} << req.adr[3:0];
    assign lane_ovf  = |lane_wide[31:16];
    assign is_read   = (req.func == MR_LOAD) || (req.func == MR_LOADZ);
    assign is_write  = (req.func == MR_STORE);
    assign adr_full  = AWID'(req.adr);
    assign store_dat = req.dat << {req.adr[3:0], 3'b000};
    assign load_raw  = dat_i >> {cap.adr[3:0], 3'b000};

    assign rd = rst && req_valid && (state == IDLE);

    always_comb begin
        done_resp     = cap;
        done_resp.dat = '0;
        if (ack_i && !err_i && (cap.func != MR_STORE))
            done_resp.dat = load_extend(cap.func, cap.sz, load_raw);
        reject_resp     = req;
        reject_resp.dat = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cap        <= '0;
            tmo        <= '0;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            we_o       <= 1'b0;
            sel_o      <= '0;
            adr_o      <= '0;
            dat_o      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap <= req;
                        tmo <= '0;
                        if ((is_read || is_write) && !lane_ovf) begin
                            state <= ACCESS;
                            cyc_o <= 1'b1;
                            stb_o <= 1'b1;
                            we_o  <= is_write;
                            sel_o <= lane_wide[15:0];
                            adr_o <= {adr_full[AWID-1:4], 4'h0};
                            dat_o <= is_write ? store_dat : '0;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp       <= reject_resp;
                        end
                    end
                end
                ACCESS: begin
                    // Error outranks ack; timeout is an error with no bus answer.
                    if (err_i || ack_i || (tmo == CW'(TOCNT - 1))) begin
                        state      <= RESP;
                        cyc_o      <= 1'b0;
                        stb_o      <= 1'b0;
                        we_o       <= 1'b0;
                        sel_o      <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= err_i || !ack_i;
                        resp       <= done_resp;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_rdy) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rfphoenix_mem_req_dispatch.sv
// Scenario bench for the memory request dispatcher with a response scoreboard.
`timescale 1ns/1ps

module tb_rfphoenix_mem_req_dispatch;
    import rfphoenix_mem_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req_valid = 1'b0;
    sMemoryRequest   req = '0;
    logic            rd;
    logic            cyc_o, stb_o, we_o;
    logic [15:0]     sel_o;
    logic [31:0]     adr_o;
    logic [127:0]    dat_o;
    logic            ack_i = 1'b0;
    logic            err_i = 1'b0;
    logic [127:0]    dat_i = '0;
    logic            resp_valid;
    sMemoryRequest   resp;
    logic            resp_err;
    logic            resp_rdy = 1'b1;

    rfphoenix_mem_req_dispatch #(.AWID(32), .TOCNT(256)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req(req), .rd(rd),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
        .dat_o(dat_o), .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
        .resp_valid(resp_valid), .resp(resp), .resp_err(resp_err), .resp_rdy(resp_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] dat;
        logic         chk_dat;
        logic         err;
        logic [7:0]   tid;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_cnt  = 0;
    int   rd_pulses = 0;
    int   cyc_hi   = 0;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (rd)    rd_pulses <= rd_pulses + 1;
        if (cyc_o) cyc_hi    <= cyc_hi + 1;
    end

    function automatic sMemoryRequest mk(input mem_func_e f, input mem_size_e s,
                                         input logic [31:0] a, input logic [127:0] d,
                                         input logic [7:0] t);
        sMemoryRequest r;
        r.func = f; r.sz = s; r.adr = a; r.dat = d; r.tid = t;
        return r;
    endfunction

    // Present a request from IDLE and release it once it has been popped.
    task automatic issue(input sMemoryRequest r);
        req = r;
        req_valid = 1'b1;
        #1;
        for (int i = 0; i < 20 && !rd; i++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (rd !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_rd: got %b expected 1", rd);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic reply(input int gap, input logic e, input logic a, input logic [127:0] d);
        repeat (gap) @(negedge clk);
        ack_i = a; err_i = e; dat_i = d;
        @(negedge clk);
        ack_i = 1'b0; err_i = 1'b0;
    endtask

    task automatic wait_resp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        exp_t dummy;
        req = mk(MR_LOAD, SZ_BYT, 32'h10, '0, 8'h01);
        req_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({rd, cyc_o, stb_o, we_o, resp_valid, resp_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {rd, cyc_o, stb_o, we_o, resp_valid, resp_err});
        end
        n_checks++;
        if (sel_o !== 16'h0 || adr_o !== 32'h0 || dat_o !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got sel %h adr %h dat %h expected zeros", sel_o, adr_o, dat_o);
        end
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        dummy.dat = '0;
    endtask

    task automatic test_load_byte();
        logic [127:0] d;
        exp_t e;
        bit got;
        sb.push_back('{dat: 128'hFFFF_FF80, chk_dat: 1'b1, err: 1'b0, tid: 8'h11});
        issue(mk(MR_LOAD, SZ_BYT, 32'h1003, '0, 8'h11));
        n_checks++;
        if (cyc_o !== 1'b1 || stb_o !== 1'b1 || we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ldb_cyc: got cyc %b stb %b we %b expected 1 1 0", cyc_o, stb_o, we_o);
        end
        n_checks++;
        if (sel_o !== 16'h0008 || adr_o !== 32'h1000) begin
            n_fail++;
            $display("FAIL ldb_sel_adr: got %h %h expected 0008 00001000", sel_o, adr_o);
        end
        d = {16{8'hA5}};
        d[31:24] = 8'h80;
        reply(1, 1'b0, 1'b1, d);
        wait_resp(got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL ldb_resp: got no response expected resp_valid");
        end else begin
            e = sb.pop_front();
            if (resp.dat !== e.dat || resp_err !== e.err || resp.tid !== e.tid || cyc_o !== 1'b0) begin
                n_fail++;
                $display("FAIL ldb_data: got dat %h err %b tid %h cyc %b expected %h %b %h 0",
                         resp.dat, resp_err, resp.tid, cyc_o, e.dat, e.err, e.tid);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_loadz_wyde();
        logic [127:0] d;
        exp_t e;
        bit got;
        sb.push_back('{dat: 128'h8001, chk_dat: 1'b1, err: 1'b0, tid: 8'h22});
        issue(mk(MR_LOADZ, SZ_WYDE, 32'h2006, '0, 8'h22));
        n_checks++;
        if (sel_o !== 16'h00C0 || adr_o !== 32'h2000) begin
            n_fail++;
            $display("FAIL ldz_sel_adr: got %h %h expected 00c0 00002000", sel_o, adr_o);
        end
        d = {16{8'hFF}};
        d[63:48] = 16'h8001;
        reply(0, 1'b0, 1'b1, d);
        wait_resp(got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL ldz_resp: got no response expected resp_valid");
        end else begin
            e = sb.pop_front();
            if (resp.dat !== e.dat || resp_err !== e.err || resp.tid !== e.tid) begin
                n_fail++;
                $display("FAIL ldz_data: got dat %h err %b tid %h expected %h %b %h",
                         resp.dat, resp_err, resp.tid, e.dat, e.err, e.tid);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_store_tetra();
        exp_t e;
        bit got;
        sb.push_back('{dat: 128'h0, chk_dat: 1'b1, err: 1'b0, tid: 8'h33});
        issue(mk(MR_STORE, SZ_TETRA, 32'h300C, 128'hDEAD_BEEF, 8'h33));
        n_checks++;
        if (we_o !== 1'b1 || sel_o !== 16'hF000 || adr_o !== 32'h3000) begin
            n_fail++;
            $display("FAIL st_ctrl: got we %b sel %h adr %h expected 1 f000 00003000", we_o, sel_o, adr_o);
        end
        n_checks++;
        if (dat_o[127:96] !== 32'hDEAD_BEEF || dat_o[95:0] !== 96'h0) begin
            n_fail++;
            $display("FAIL st_dat: got %h expected deadbeef in [127:96], zero below", dat_o);
        end
        reply(0, 1'b0, 1'b1, {4{32'h1234_5678}});
        wait_resp(got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL st_resp: got no response expected resp_valid");
        end else begin
            e = sb.pop_front();
            if (resp.dat !== e.dat || resp_err !== e.err || resp.tid !== e.tid ||
                resp.adr !== 32'h300C || resp.func !== MR_STORE || we_o !== 1'b0) begin
                n_fail++;
                $display("FAIL st_data: got dat %h err %b tid %h adr %h we %b expected %h %b %h 0000300c 0",
                         resp.dat, resp_err, resp.tid, resp.adr, we_o, e.dat, e.err, e.tid);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reject(input mem_func_e f, input mem_size_e s, input logic [31:0] a,
                               input logic [7:0] t);
        exp_t e;
        bit got;
        int rd0, cyc0;
        rd0 = rd_pulses;
        cyc0 = cyc_hi;
        sb.push_back('{dat: 128'h0, chk_dat: 1'b0, err: 1'b1, tid: t});
        issue(mk(f, s, a, '0, t));
        wait_resp(got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL rej_resp: got no response expected resp_valid for tid %h", t);
        end else begin
            e = sb.pop_front();
            if (resp_err !== e.err || resp.tid !== e.tid) begin
                n_fail++;
                $display("FAIL rej_err: got err %b tid %h expected %b %h", resp_err, resp.tid, e.err, e.tid);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (cyc_hi != cyc0 || rd_pulses != rd0 + 1) begin
            n_fail++;
            $display("FAIL rej_bus: got cyc cycles %0d rd pulses %0d expected 0 1", cyc_hi - cyc0, rd_pulses - rd0);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        bit got;
        int cyc0;
        cyc0 = cyc_hi;
        sb.push_back('{dat: 128'h0, chk_dat: 1'b0, err: 1'b1, tid: 8'h44});
        issue(mk(MR_LOAD, SZ_TETRA, 32'h4000, '0, 8'h44));
        wait_resp(got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL tmo_resp: got no response expected resp_valid");
        end else begin
            e = sb.pop_front();
            if (resp_err !== e.err || resp.tid !== e.tid || cyc_o !== 1'b0) begin
                n_fail++;
                $display("FAIL tmo_err: got err %b tid %h cyc %b expected 1 %h 0", resp_err, resp.tid, cyc_o, e.tid);
            end
        end
        n_checks++;
        if (cyc_hi - cyc0 != 256) begin
            n_fail++;
            $display("FAIL tmo_len: got %0d cycles expected 256", cyc_hi - cyc0);
        end
        @(negedge clk);
    endtask

    task automatic test_bus_err();
        exp_t e;
        bit got;
        sb.push_back('{dat: 128'h0, chk_dat: 1'b0, err: 1'b1, tid: 8'h55});
        issue(mk(MR_LOAD, SZ_TETRA, 32'h5000, '0, 8'h55));
        reply(2, 1'b1, 1'b1, {4{32'hCAFE_F00D}});
        wait_resp(got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL berr_resp: got no response expected resp_valid");
        end else begin
            e = sb.pop_front();
            if (resp_err !== e.err || resp.tid !== e.tid || cyc_o !== 1'b0) begin
                n_fail++;
                $display("FAIL berr_err: got err %b tid %h cyc %b expected 1 %h 0", resp_err, resp.tid, cyc_o, e.tid);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_ack_outside();
        ack_i = 1'b1;
        err_i = 1'b1;
        repeat (2) @(negedge clk);
        ack_i = 1'b0;
        err_i = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ack: got resp_valid %b cyc %b expected 0 0", resp_valid, cyc_o);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int spurious;
        issue(mk(MR_LOAD, SZ_BYT, 32'h6001, '0, 8'h77));
        rst = 1'b0;
        #1;
        n_checks++;
        if (cyc_o !== 1'b0 || stb_o !== 1'b0 || sel_o !== 16'h0 || adr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got cyc %b stb %b sel %h adr %h expected 0 0 0000 00000000", cyc_o, stb_o, sel_o, adr_o);
        end
        @(negedge clk);
        rst = 1'b1;
        ack_i = 1'b1;
        spurious = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ack_i = 1'b0;
            if (resp_valid !== 1'b0 || cyc_o !== 1'b0) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL rst_noresp: got %0d cycles with activity expected 0", spurious);
        end
    endtask

    task automatic test_resp_hold();
        logic [127:0] d;
        sMemoryRequest snap;
        exp_t e;
        bit got;
        int bad;
        resp_rdy = 1'b0;
        sb.push_back('{dat: 128'hFFFF_8123, chk_dat: 1'b1, err: 1'b0, tid: 8'h66});
        issue(mk(MR_LOAD, SZ_WYDE, 32'h6002, '0, 8'h66));
        d = '0;
        d[31:16] = 16'h8123;
        reply(0, 1'b0, 1'b1, d);
        wait_resp(got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL hold_resp: got no response expected resp_valid");
        end else begin
            e = sb.pop_front();
            if (resp.dat !== e.dat || resp_err !== e.err || resp.tid !== e.tid) begin
                n_fail++;
                $display("FAIL hold_data: got dat %h err %b tid %h expected %h %b %h",
                         resp.dat, resp_err, resp.tid, e.dat, e.err, e.tid);
            end
        end
        snap = resp;
        req = mk(MR_LOAD, SZ_BYT, 32'h9000, '0, 8'h99);
        req_valid = 1'b1;
        dat_i = {8{16'hBEEF}};
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (resp_valid !== 1'b1 || resp !== snap || resp_err !== 1'b0 || rd !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad);
        end
        req_valid = 1'b0;
        resp_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: got resp_valid %b expected 0", resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] d;
        exp_t e;
        int t_now, t_prev;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            req = mk(MR_LOADZ, SZ_BYT, 32'h7000 + k, '0, 8'h70 + 8'(k));
            req_valid = 1'b1;
            #1;
            t_now = cyc_cnt;
            n_checks++;
            if (rd !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_rd%0d: got %b expected 1", k, rd);
            end
            if (k > 0) begin
                n_checks++;
                if (t_now - t_prev > 4) begin
                    n_fail++;
                    $display("FAIL b2b_rate%0d: got %0d clocks expected <= 4", k, t_now - t_prev);
                end
            end
            t_prev = t_now;
            sb.push_back('{dat: 128'(8'h10 + 8'(k)), chk_dat: 1'b1, err: 1'b0, tid: 8'h70 + 8'(k)});
            d = {16{8'hEE}};
            d[8*k +: 8] = 8'h10 + 8'(k);
            @(negedge clk);
            ack_i = 1'b1;
            dat_i = d;
            @(negedge clk);
            ack_i = 1'b0;
            n_checks++;
            if (resp_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_valid%0d: got %b expected 1", k, resp_valid);
            end else begin
                e = sb.pop_front();
                if (resp.dat !== e.dat || resp_err !== e.err || resp.tid !== e.tid) begin
                    n_fail++;
                    $display("FAIL b2b_data%0d: got dat %h err %b tid %h expected %h %b %h",
                             k, resp.dat, resp_err, resp.tid, e.dat, e.err, e.tid);
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_load_byte();
        test_loadz_wyde();
        test_store_tetra();
        test_reject(MR_LOAD, SZ_OCTA, 32'h400A, 8'h3A);
        test_reject(MR_CACHE, SZ_BYT, 32'h4100, 8'h3B);
        test_timeout();
        test_bus_err();
        test_ack_outside();
        test_reset_mid_access();
        test_resp_hold();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
